// File: rtl/tetris_pkg.sv
// Shared tetris datapath types: piece IDs, queue FSM states and the anti-repeat helper.
package tetris_pkg;

    localparam int unsigned PIECE_W = 2;
    localparam int unsigned CNT_W   = 16;

    localparam logic [PIECE_W-1:0] PIECE_I = PIECE_W'(0);
    localparam logic [PIECE_W-1:0] PIECE_O = PIECE_W'(1);
    localparam logic [PIECE_W-1:0] PIECE_T = PIECE_W'(2);
    localparam logic [PIECE_W-1:0] PIECE_L = PIECE_W'(3);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Bump a sample that would repeat the previous push; the first push after restart passes through.
    function automatic logic [PIECE_W-1:0] anti_repeat(
        input logic [PIECE_W-1:0] sample,
        input logic [PIECE_W-1:0] last,
        input logic               bypass
    );
        return (!bypass && (sample == last)) ? sample + PIECE_W'(1) : sample;
    endfunction

endpackage

// File: rtl/piece_shift_q.sv
// DEPTH+1 entry piece shift register: push pops the head and appends at the tail, load_head overwrites the head.
module piece_shift_q
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  logic [PIECE_W-1:0]             i_push_val,
    input  logic                           i_load_head,
    input  logic [PIECE_W-1:0]             i_head_val,
    output logic [(DEPTH+1)*PIECE_W-1:0]   o_entries,
    output logic [PIECE_W-1:0]             o_last
);

    localparam int unsigned Q_W = (DEPTH + 1) * PIECE_W;

    // Entry 0 (head) lives in the low bits, the tail in the high bits.
    logic [Q_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_push) begin
            r_q <= {i_push_val, r_q[Q_W-1:PIECE_W]};
        end else if (i_load_head) begin
            r_q[PIECE_W-1:0] <= i_head_val;
        end
    end

    assign o_entries = r_q;
    assign o_last    = r_q[Q_W-1 -: PIECE_W];

endmodule

// File: rtl/piece_queue.sv
// Next-piece preview queue with anti-repeat filter, valid/take head handshake and once-per-piece hold slot.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic                    clka,
    input  logic                    restart,
    input  logic [PIECE_W-1:0]      random,
    input  logic                    take,
    input  logic                    hold_req,
    output logic [PIECE_W-1:0]      piece_out,
    output logic                    piece_valid,
    output logic [DEPTH*PIECE_W-1:0] preview,
    output logic [PIECE_W-1:0]      hold_piece,
    output logic                    hold_valid,
    output logic [CNT_W-1:0]        piece_count
);

    localparam int unsigned ENT    = DEPTH + 1;
    localparam int unsigned FILL_W = $clog2(ENT);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [FILL_W-1:0]         r_fill_cnt;
    logic                      r_piece_valid;
    logic [PIECE_W-1:0]        r_hold_piece;
    logic                      r_hold_valid;
    logic                      r_hold_used;
    logic [CNT_W-1:0]          r_piece_count;

    logic                      w_push;
    logic                      w_load_head;
    logic                      w_take_acc;
    logic                      w_hold_cap;
    logic                      w_swap;
    logic                      w_first;
    logic [PIECE_W-1:0]        w_sample;
    logic [PIECE_W-1:0]        w_last;
    logic [PIECE_W-1:0]        w_head;
    logic [ENT*PIECE_W-1:0]    w_entries;

    piece_shift_q #(.DEPTH(DEPTH)) u_shift_q (
        .i_clk       (clka),
        .i_rst       (restart),
        .i_push      (w_push),
        .i_push_val  (w_sample),
        .i_load_head (w_load_head),
        .i_head_val  (r_hold_piece),
        .o_entries   (w_entries),
        .o_last      (w_last)
    );

    assign w_head   = w_entries[PIECE_W-1:0];
    assign w_first  = (r_state == ST_FILL) && (r_fill_cnt == '0);
    assign w_sample = anti_repeat(random, w_last, w_first);

    always_ff @(posedge clka) begin
        if (restart) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle queue/hold actions; take beats hold_req, FILL ignores both.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_load_head = 1'b0;
        w_take_acc  = 1'b0;
        w_hold_cap  = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_push = 1'b1;
                if (r_fill_cnt == FILL_W'(DEPTH)) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (take) begin
                    w_push     = 1'b1;
                    w_take_acc = 1'b1;
                end else if (hold_req && !r_hold_used) begin
                    if (!r_hold_valid) begin
                        w_hold_cap = 1'b1;
                        w_push     = 1'b1;
                    end else begin
                        w_swap      = 1'b1;
                        w_load_head = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            r_fill_cnt    <= '0;
            r_piece_valid <= 1'b0;
            r_hold_piece  <= PIECE_I;
            r_hold_valid  <= 1'b0;
            r_hold_used   <= 1'b0;
            r_piece_count <= '0;
        end else begin
            if (r_state == ST_FILL) begin
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end
            r_piece_valid <= (w_state_nxt == ST_READY);
            if (w_take_acc) begin
                r_piece_count <= r_piece_count + CNT_W'(1);
                r_hold_used   <= 1'b0;
            end
            if (w_hold_cap || w_swap) begin
                r_hold_piece <= w_head;
                r_hold_valid <= 1'b1;
                r_hold_used  <= 1'b1;
            end
        end
    end

    assign piece_out   = w_head;
    assign preview     = w_entries[ENT*PIECE_W-1:PIECE_W];
    assign piece_valid = r_piece_valid;
    assign hold_piece  = r_hold_piece;
    assign hold_valid  = r_hold_valid;
    assign piece_count = r_piece_count;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: queue-level reference model checked every cycle plus literal checkpoints.
module tb_piece_queue;

    localparam int unsigned DEPTH = 3;

    logic               clka = 1'b0;
    logic               restart = 1'b1;
    logic [1:0]         random = 2'd0;
    logic               take = 1'b0;
    logic               hold_req = 1'b0;
    logic [1:0]         piece_out;
    logic               piece_valid;
    logic [2*DEPTH-1:0] preview;
    logic [1:0]         hold_piece;
    logic               hold_valid;
    logic [15:0]        piece_count;

    int checks = 0;
    int errors = 0;

    piece_queue #(.DEPTH(DEPTH)) dut (
        .clka        (clka),
        .restart     (restart),
        .random      (random),
        .take        (take),
        .hold_req    (hold_req),
        .piece_out   (piece_out),
        .piece_valid (piece_valid),
        .preview     (preview),
        .hold_piece  (hold_piece),
        .hold_valid  (hold_valid),
        .piece_count (piece_count)
    );

    always #5 clka = ~clka;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue of piece IDs plus hold bookkeeping.
    int mq[$];
    int mhold, mlast, mfill, mcnt;
    bit mhv, mused, mready, mfirst, minit;

    function automatic int filt(input int r);
        if (!mfirst && r == mlast) return (r + 1) % 4;
        return r;
    endfunction

    function automatic void mpush(input int r);
        int s;
        s = filt(r);
        void'(mq.pop_front());
        mq.push_back(s);
        mlast  = s;
        mfirst = 1'b0;
    endfunction

    always @(posedge clka) begin
        logic s_rst, s_take, s_hold;
        int   s_rnd, t;
        logic [2*DEPTH-1:0] ep;
        s_rst  = restart;
        s_take = take;
        s_hold = hold_req;
        s_rnd  = int'(random);
        if (s_rst) begin
            mq.delete();
            for (int i = 0; i <= DEPTH; i++) mq.push_back(0);
            mhold = 0; mhv = 0; mused = 0; mready = 0; mfill = 0; mcnt = 0;
            mfirst = 1; mlast = 0; minit = 1;
        end else if (minit) begin
            if (!mready) begin
                mpush(s_rnd);
                mfill++;
                if (mfill == DEPTH + 1) mready = 1;
            end else if (s_take) begin
                mpush(s_rnd);
                mcnt  = (mcnt + 1) % 65536;
                mused = 0;
            end else if (s_hold && !mused) begin
                if (!mhv) begin
                    mhold = mq[0];
                    mhv   = 1;
                    mpush(s_rnd);
                end else begin
                    t     = mq[0];
                    mq[0] = mhold;
                    mhold = t;
                end
                mused = 1;
            end
        end
        #1;
        if (minit) begin
            chk("m_valid", 32'(piece_valid), 32'(mready));
            chk("m_count", 32'(piece_count), 32'(mcnt));
            chk("m_hold_valid", 32'(hold_valid), 32'(mhv));
            chk("m_hold_piece", 32'(hold_piece), 32'(mhold));
            if (mready) begin
                ep = '0;
                for (int i = 1; i <= DEPTH; i++) ep[2*(i-1) +: 2] = 2'(mq[i]);
                chk("m_piece_out", 32'(piece_out), 32'(mq[0]));
                chk("m_preview", 32'(preview), 32'(ep));
            end
        end
    end

    task automatic cyc(input logic r, input logic t, input logic h, input logic [1:0] rn);
        restart  = r;
        take     = t;
        hold_req = h;
        random   = rn;
        @(posedge clka);
        #2;
    endtask

    initial begin
        logic [1:0] rn;
        cyc(1, 0, 0, 0);
        chk("rst_valid", 32'(piece_valid), 0);
        chk("rst_out", 32'(piece_out), 0);
        chk("rst_preview", 32'(preview), 0);
        chk("rst_count", 32'(piece_count), 0);
        chk("rst_hold_valid", 32'(hold_valid), 0);

        // Fill with 0,1,2,3
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 2);
        chk("fill_not_ready", 32'(piece_valid), 0);
        cyc(0, 0, 0, 3);
        chk("fill_valid", 32'(piece_valid), 1);
        chk("fill_out", 32'(piece_out), 0);
        chk("fill_preview", 32'(preview), 32'h39);

        // Anti-repeat on take
        cyc(0, 1, 0, 3);
        chk("ar1_out", 32'(piece_out), 1);
        chk("ar1_preview", 32'(preview), 32'h0E);
        cyc(0, 1, 0, 0);
        chk("ar2_preview", 32'(preview), 32'h13);
        chk("ar2_count", 32'(piece_count), 2);

        // First hold, then ignored second hold
        cyc(0, 0, 1, 2);
        chk("hold_piece", 32'(hold_piece), 2);
        chk("hold_valid", 32'(hold_valid), 1);
        chk("hold_out", 32'(piece_out), 3);
        chk("hold_count", 32'(piece_count), 2);
        cyc(0, 0, 1, 1);
        chk("hold2_out", 32'(piece_out), 3);
        chk("hold2_piece", 32'(hold_piece), 2);

        // Take then swap
        cyc(0, 1, 0, 2);
        chk("take3_out", 32'(piece_out), 0);
        chk("take3_count", 32'(piece_count), 3);
        cyc(0, 0, 1, 0);
        chk("swap_out", 32'(piece_out), 2);
        chk("swap_hold", 32'(hold_piece), 0);
        chk("swap_preview", 32'(preview), 32'h39);

        // take + hold together: only the pop
        cyc(0, 1, 1, 1);
        chk("prio_out", 32'(piece_out), 1);
        chk("prio_hold", 32'(hold_piece), 0);
        chk("prio_count", 32'(piece_count), 4);

        // Restart mid-stream
        cyc(1, 0, 0, 0);
        chk("rst2_valid", 32'(piece_valid), 0);
        chk("rst2_hold_valid", 32'(hold_valid), 0);
        chk("rst2_count", 32'(piece_count), 0);
        chk("rst2_out", 32'(piece_out), 0);

        // Refill with take/hold asserted and repeated samples
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 1);
        chk("refill_not_ready", 32'(piece_valid), 0);
        cyc(0, 1, 1, 1);
        chk("refill_valid", 32'(piece_valid), 1);
        chk("refill_out", 32'(piece_out), 1);
        chk("refill_preview", 32'(preview), 32'h26);
        chk("refill_count", 32'(piece_count), 0);
        chk("refill_hold_valid", 32'(hold_valid), 0);

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            rn = 2'($urandom_range(0, 3));
            cyc(0, 1, 0, rn);
        end
        chk("wrap_ffff", 32'(piece_count), 32'hFFFF);
        cyc(0, 1, 0, 2);
        chk("wrap_zero", 32'(piece_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
